// File: rtl/scale_buf_writer.sv
// scale_buf_writer
//   Decimates an RGB565 raster stream by 2^DECIM_SHIFT on both axes and
//   writes the kept pixels into a frame RAM in raster order.
//   Optional build macro: SCALE_BUF_DBL_BUF_EN. When it is defined, wr_bank
//   flips after every completed frame so the scaler can read the other bank.
//   When it is undefined, wr_bank is tied to 0.
//
// Ports
//   clk        : single clock
//   rst        : asynchronous active-low reset
//   vs_in      : vertical sync, a rising edge starts a frame
//   de_in      : data enable, high on active pixels
//   data_in    : RGB565 pixel, valid while de_in=1
//   wr_en      : frame-RAM write strobe, one cycle after the pixel sample
//   wr_addr    : frame-RAM write address, row*OUT_COL+col
//   wr_data    : frame-RAM write data
//   wr_bank    : bank being written; the reader uses ~wr_bank
//   frame_done : one-cycle pulse when a frame has been written
//   err_ovf    : sticky, set when a kept pixel found the RAM already full
module scale_buf_writer #(
   parameter int unsigned SRC_COL     = 1280,
   parameter int unsigned SRC_ROW     = 720,
   parameter int unsigned DECIM_SHIFT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vs_in,
   input  logic        de_in,
   input  logic [15:0] data_in,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [15:0] wr_data,
   output logic        wr_bank,
   output logic        frame_done,
   output logic        err_ovf
);

   localparam int unsigned OUT_COL   = SRC_COL >> DECIM_SHIFT;
   localparam int unsigned OUT_ROW   = SRC_ROW >> DECIM_SHIFT;
   localparam int unsigned OUT_TOTAL = OUT_COL * OUT_ROW;
   localparam int unsigned HW        = $clog2(SRC_COL + 1);
   localparam int unsigned VW        = $clog2(SRC_ROW + 1);
   localparam int unsigned AW        = 17;
   localparam int unsigned DEC_MASK  = (32'd1 << DECIM_SHIFT) - 32'd1;

   localparam logic [HW-1:0] COL_LIM  = HW'(SRC_COL);
   localparam logic [VW-1:0] ROW_LIM  = VW'(SRC_ROW);
   localparam logic [VW-1:0] ROW_LAST = VW'(SRC_ROW - 1);
   localparam logic [HW-1:0] H_MASK   = HW'(DEC_MASK);
   localparam logic [VW-1:0] V_MASK   = VW'(DEC_MASK);
   localparam logic [AW-1:0] ADDR_LIM = AW'(OUT_TOTAL);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_DE = 2'd1,
      ACTIVE  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [HW-1:0] h_cnt, h_cnt_d;
   logic [VW-1:0] v_cnt, v_cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          vs_q;
   logic          de_q;
   logic          wr_en_d;
   logic [15:0]   wr_addr_d;
   logic [15:0]   wr_data_d;
   logic          frame_done_d;
   logic          err_ovf_d;
   logic          take_pix;

   logic vs_rise;
   logic de_fall;
   logic pix_keep;

   assign vs_rise = vs_in & ~vs_q;
   assign de_fall = ~de_in & de_q;

   // Kept pixel: inside the source window and on the decimation grid.
   assign pix_keep = (h_cnt < COL_LIM) && (v_cnt < ROW_LIM) &&
                     ((h_cnt & H_MASK) == '0) && ((v_cnt & V_MASK) == '0);

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         h_cnt      <= '0;
         v_cnt      <= '0;
         addr_q     <= '0;
         vs_q       <= 1'b0;
         de_q       <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         err_ovf    <= 1'b0;
      end else begin
         state_q    <= state_d;
         h_cnt      <= h_cnt_d;
         v_cnt      <= v_cnt_d;
         addr_q     <= addr_d;
         vs_q       <= vs_in;
         de_q       <= de_in;
         wr_en      <= wr_en_d;
         wr_addr    <= wr_addr_d;
         wr_data    <= wr_data_d;
         frame_done <= frame_done_d;
         err_ovf    <= err_ovf_d;
      end
   end

   // Next-state and output decode; a frame restart always beats a pixel.
   always_comb begin
      state_d      = state_q;
      h_cnt_d      = h_cnt;
      v_cnt_d      = v_cnt;
      addr_d       = addr_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr;
      wr_data_d    = wr_data;
      frame_done_d = 1'b0;
      err_ovf_d    = err_ovf;
      take_pix     = 1'b0;

      case (state_q)
         IDLE: begin
            if (vs_rise) begin
               state_d = WAIT_DE;
               h_cnt_d = '0;
               v_cnt_d = '0;
               addr_d  = '0;
            end
         end
         WAIT_DE: begin
            if (vs_rise) begin
               h_cnt_d = '0;
               v_cnt_d = '0;
               addr_d  = '0;
            end else if (de_in) begin
               state_d  = ACTIVE;
               take_pix = 1'b1;
            end
         end
         ACTIVE: begin
            if (vs_rise) begin
               frame_done_d = 1'b1;
               state_d      = WAIT_DE;
               h_cnt_d      = '0;
               v_cnt_d      = '0;
               addr_d       = '0;
            end else if (de_in) begin
               take_pix = 1'b1;
            end else if (de_fall) begin
               h_cnt_d = '0;
               v_cnt_d = v_cnt + VW'(1);
               // Last source line finished: frame complete, wait for next sync.
               if (v_cnt == ROW_LAST) begin
                  frame_done_d = 1'b1;
                  state_d      = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (take_pix) begin
         // Saturate so over-long lines stay outside the window.
         if (h_cnt < COL_LIM) begin
            h_cnt_d = h_cnt + HW'(1);
         end
         if (pix_keep) begin
            if (addr_q == ADDR_LIM) begin
               err_ovf_d = 1'b1;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q[15:0];
               wr_data_d = data_in;
               addr_d    = addr_q + AW'(1);
            end
         end
      end
   end

`ifdef SCALE_BUF_DBL_BUF_EN
   // Swap banks the cycle after each completed frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_bank <= 1'b0;
      end else if (frame_done) begin
         wr_bank <= ~wr_bank;
      end
   end
`else
   assign wr_bank = 1'b0;
`endif

endmodule

// File: tb/tb_scale_buf_writer.sv
// tb_scale_buf_writer
//   Drives four differently parameterised scale_buf_writer instances from one
//   shared video stream and compares their write/frame_done event streams to
//   a frame-level reference model.
module tb_scale_buf_writer;

   localparam int N = 4;

   function automatic int cols(int i);
      case (i)
         0:       cols = 8;
         1:       cols = 12;
         2:       cols = 9;
         default: cols = 6;
      endcase
   endfunction

   function automatic int rows(int i);
      case (i)
         0:       rows = 4;
         1:       rows = 8;
         2:       rows = 4;
         default: rows = 3;
      endcase
   endfunction

   function automatic int shf(int i);
      case (i)
         0:       shf = 1;
         1:       shf = 2;
         2:       shf = 1;
         default: shf = 0;
      endcase
   endfunction

   logic          clk = 1'b0;
   logic          rst;
   logic          vs_in;
   logic          de_in;
   logic [15:0]   data_in;
   logic [N-1:0]  wr_en;
   logic [N-1:0]  wr_bank;
   logic [N-1:0]  frame_done;
   logic [N-1:0]  err_ovf;
   logic [15:0]   wr_addr [N];
   logic [15:0]   wr_data [N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      scale_buf_writer #(
         .SRC_COL     (cols(g)),
         .SRC_ROW     (rows(g)),
         .DECIM_SHIFT (shf(g))
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .vs_in      (vs_in),
         .de_in      (de_in),
         .data_in    (data_in),
         .wr_en      (wr_en[g]),
         .wr_addr    (wr_addr[g]),
         .wr_data    (wr_data[g]),
         .wr_bank    (wr_bank[g]),
         .frame_done (frame_done[g]),
         .err_ovf    (err_ovf[g])
      );
   end

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   // Event = {cycle, is_frame_done, addr, data}
   logic [64:0] exp_q [N][$];
   logic [64:0] got_q [N][$];

   bit m_open [N];
   bit m_act  [N];
   bit m_err  [N];
   int m_addr [N];
   int m_nfd  [N];

   function automatic logic [64:0] ev(int c, bit fd, logic [15:0] a, logic [15:0] d);
      ev = {32'(c), fd, a, d};
   endfunction

   function automatic logic bank_exp(int i);
`ifdef SCALE_BUF_DBL_BUF_EN
      bank_exp = ((m_nfd[i] % 2) == 1);
`else
      bank_exp = 1'b0;
`endif
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int d = 0; d < N; d++) begin
         if (wr_en[d] === 1'b1) got_q[d].push_back(ev(cyc, 1'b0, wr_addr[d], wr_data[d]));
         if (frame_done[d] === 1'b1) got_q[d].push_back(ev(cyc, 1'b1, 16'h0, 16'h0));
      end
   end

   // ---------------- reference model (frame-level view) ----------------
   function automatic void m_reset();
      for (int i = 0; i < N; i++) begin
         m_open[i] = 1'b0; m_act[i] = 1'b0; m_err[i] = 1'b0;
         m_addr[i] = 0;    m_nfd[i] = 0;
      end
   endfunction

   function automatic void m_vs(int sc);
      for (int i = 0; i < N; i++) begin
         if (m_open[i] && m_act[i]) begin
            exp_q[i].push_back(ev(sc, 1'b1, 16'h0, 16'h0));
            m_nfd[i]++;
         end
         m_open[i] = 1'b1; m_act[i] = 1'b0; m_addr[i] = 0;
      end
   endfunction

   function automatic void m_pix(int v, int h, logic [15:0] d, int sc);
      for (int i = 0; i < N; i++) begin
         int f;
         int total;
         f     = 1 << shf(i);
         total = (cols(i) >> shf(i)) * (rows(i) >> shf(i));
         if (m_open[i]) begin
            m_act[i] = 1'b1;
            if (v < rows(i) && h < cols(i) && (v % f) == 0 && (h % f) == 0) begin
               if (m_addr[i] < total) begin
                  exp_q[i].push_back(ev(sc, 1'b0, 16'(m_addr[i]), d));
                  m_addr[i]++;
               end else begin
                  m_err[i] = 1'b1;
               end
            end
         end
      end
   endfunction

   function automatic void m_line_end(int v, int sc);
      for (int i = 0; i < N; i++) begin
         if (m_open[i] && m_act[i] && (v + 1) >= rows(i)) begin
            exp_q[i].push_back(ev(sc, 1'b1, 16'h0, 16'h0));
            m_nfd[i]++;
            m_open[i] = 1'b0; m_act[i] = 1'b0;
         end
      end
   endfunction

   // ---------------- stimulus ----------------
   task automatic drive(input logic vs, input logic de, input logic [15:0] d);
      @(posedge clk); #1;
      vs_in = vs; de_in = de; data_in = d;
   endtask

   task automatic send_vs(input bit with_pix);
      drive(1'b1, with_pix, 16'($urandom));
      m_vs(cyc + 1);
      repeat (int'($urandom_range(2, 0))) drive(1'b1, 1'b0, 16'h0);
      drive(1'b0, 1'b0, 16'h0);
   endtask

   task automatic send_line(input int v, input int len, input bit pat);
      logic [15:0] d;
      for (int h = 0; h < len; h++) begin
         d = pat ? 16'(h + 16 * v) : 16'($urandom);
         drive(1'b0, 1'b1, d);
         m_pix(v, h, d, cyc + 1);
      end
      drive(1'b0, 1'b0, 16'h0);
      m_line_end(v, cyc + 1);
      repeat (int'($urandom_range(2, 0))) drive(1'b0, 1'b0, 16'h0);
   endtask

   task automatic send_frame(input int lines, input int lmin, input int lmax, input bit pat);
      send_vs(1'b0);
      for (int v = 0; v < lines; v++) send_line(v, int'($urandom_range(lmax, lmin)), pat);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0; vs_in = 1'b0; de_in = 1'b0; data_in = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         checks++;
         if ({wr_en[i], wr_addr[i], wr_data[i], wr_bank[i], frame_done[i], err_ovf[i]} !== 36'h0) begin
            errors++;
            $display("FAIL reset dut%0d outputs got en=%b addr=%h data=%h bank=%b fd=%b ovf=%b want all 0",
                     i, wr_en[i], wr_addr[i], wr_data[i], wr_bank[i], frame_done[i], err_ovf[i]);
         end
      end
      rst = 1'b1;
      m_reset();
      repeat (2) drive(1'b0, 1'b0, 16'h0);
   endtask

   task automatic test_ref_frame();
      logic [15:0] ref_d [8];
      logic [64:0] e;
      int nw, nfd;
      ref_d = '{16'h00, 16'h02, 16'h04, 16'h06, 16'h20, 16'h22, 16'h24, 16'h26};
      send_frame(4, 8, 8, 1'b1);
      repeat (4) drive(1'b0, 1'b0, 16'h0);
      nw = 0; nfd = 0;
      for (int k = 0; k < got_q[0].size(); k++) begin
         e = got_q[0][k];
         if (e[32]) nfd++;
         else begin
            if (nw < 8) begin
               checks++;
               if (e[31:16] !== 16'(nw) || e[15:0] !== ref_d[nw]) begin
                  errors++;
                  $display("FAIL ref_frame write%0d got addr=%h data=%h want addr=%h data=%h",
                           nw, e[31:16], e[15:0], 16'(nw), ref_d[nw]);
               end
            end
            nw++;
         end
      end
      checks++;
      if (nw != 8 || nfd != 1) begin
         errors++;
         $display("FAIL ref_frame counts got writes=%0d fd=%0d want writes=8 fd=1", nw, nfd);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (got_q[i].size() != exp_q[i].size()) begin
            errors++;
            $display("FAIL ref_frame dut%0d events got %0d want %0d", i, got_q[i].size(), exp_q[i].size());
         end
         for (int k = 0; k < got_q[i].size() && k < exp_q[i].size(); k++) begin
            checks++;
            if (got_q[i][k] !== exp_q[i][k]) begin
               errors++;
               $display("FAIL ref_frame dut%0d ev%0d got %h want %h", i, k, got_q[i][k], exp_q[i][k]);
            end
         end
         checks++;
         if (err_ovf[i] !== m_err[i] || wr_bank[i] !== bank_exp(i)) begin
            errors++;
            $display("FAIL ref_frame dut%0d ovf/bank got %b/%b want %b/%b", i, err_ovf[i], wr_bank[i], m_err[i], bank_exp(i));
         end
         got_q[i].delete(); exp_q[i].delete();
      end
   endtask

   task automatic test_long_lines();
      int nw;
      logic [64:0] e;
      send_frame(4, 12, 12, 1'b0);
      repeat (4) drive(1'b0, 1'b0, 16'h0);
      nw = 0;
      for (int k = 0; k < got_q[0].size(); k++) begin
         e = got_q[0][k];
         if (!e[32]) nw++;
      end
      checks++;
      if (nw != 8 || err_ovf[0] !== 1'b0) begin
         errors++;
         $display("FAIL long_lines dut0 got writes=%0d ovf=%b want writes=8 ovf=0", nw, err_ovf[0]);
      end
      checks++;
      if (err_ovf[2] !== 1'b1) begin
         errors++;
         $display("FAIL long_lines dut2 overflow got %b want 1", err_ovf[2]);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (got_q[i].size() != exp_q[i].size()) begin
            errors++;
            $display("FAIL long_lines dut%0d events got %0d want %0d", i, got_q[i].size(), exp_q[i].size());
         end
         for (int k = 0; k < got_q[i].size() && k < exp_q[i].size(); k++) begin
            checks++;
            if (got_q[i][k] !== exp_q[i][k]) begin
               errors++;
               $display("FAIL long_lines dut%0d ev%0d got %h want %h", i, k, got_q[i][k], exp_q[i][k]);
            end
         end
         checks++;
         if (err_ovf[i] !== m_err[i] || wr_bank[i] !== bank_exp(i)) begin
            errors++;
            $display("FAIL long_lines dut%0d ovf/bank got %b/%b want %b/%b", i, err_ovf[i], wr_bank[i], m_err[i], bank_exp(i));
         end
         got_q[i].delete(); exp_q[i].delete();
      end
   endtask

   task automatic test_vs_mid_frame();
      int nw_before;
      bit seen_fd, got_first;
      logic [15:0] first_addr;
      logic [64:0] e;
      logic [15:0] d;
      send_vs(1'b0);
      send_line(0, 8, 1'b0);
      send_line(1, 8, 1'b0);
      for (int h = 0; h < 4; h++) begin
         d = 16'($urandom);
         drive(1'b0, 1'b1, d);
         m_pix(2, h, d, cyc + 1);
      end
      // Sync lands on pixel h=4 of line 2, which is on the grid for dut0.
      send_vs(1'b1);
      for (int v = 0; v < 4; v++) send_line(v, 8, 1'b0);
      repeat (4) drive(1'b0, 1'b0, 16'h0);
      nw_before = 0; seen_fd = 1'b0; got_first = 1'b0; first_addr = 16'hffff;
      for (int k = 0; k < got_q[0].size(); k++) begin
         e = got_q[0][k];
         if (e[32]) begin
            if (!seen_fd) seen_fd = 1'b1;
         end else if (!seen_fd) begin
            nw_before++;
         end else if (!got_first) begin
            got_first  = 1'b1;
            first_addr = e[31:16];
         end
      end
      checks++;
      if (nw_before != 6 || !seen_fd || first_addr !== 16'h0) begin
         errors++;
         $display("FAIL vs_mid_frame dut0 got writes_before=%0d fd_seen=%0d next_addr=%h want 6 1 0000",
                  nw_before, seen_fd, first_addr);
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (got_q[i].size() != exp_q[i].size()) begin
            errors++;
            $display("FAIL vs_mid_frame dut%0d events got %0d want %0d", i, got_q[i].size(), exp_q[i].size());
         end
         for (int k = 0; k < got_q[i].size() && k < exp_q[i].size(); k++) begin
            checks++;
            if (got_q[i][k] !== exp_q[i][k]) begin
               errors++;
               $display("FAIL vs_mid_frame dut%0d ev%0d got %h want %h", i, k, got_q[i][k], exp_q[i][k]);
            end
         end
         checks++;
         if (err_ovf[i] !== m_err[i] || wr_bank[i] !== bank_exp(i)) begin
            errors++;
            $display("FAIL vs_mid_frame dut%0d ovf/bank got %b/%b want %b/%b", i, err_ovf[i], wr_bank[i], m_err[i], bank_exp(i));
         end
         got_q[i].delete(); exp_q[i].delete();
      end
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 8; f++) begin
         send_frame(int'($urandom_range(9, 2)), 6, 14, 1'b0);
      end
      send_vs(1'b0);
      repeat (4) drive(1'b0, 1'b0, 16'h0);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (got_q[i].size() != exp_q[i].size()) begin
            errors++;
            $display("FAIL random dut%0d events got %0d want %0d", i, got_q[i].size(), exp_q[i].size());
         end
         for (int k = 0; k < got_q[i].size() && k < exp_q[i].size(); k++) begin
            checks++;
            if (got_q[i][k] !== exp_q[i][k]) begin
               errors++;
               $display("FAIL random dut%0d ev%0d got %h want %h", i, k, got_q[i][k], exp_q[i][k]);
            end
         end
         checks++;
         if (err_ovf[i] !== m_err[i] || wr_bank[i] !== bank_exp(i)) begin
            errors++;
            $display("FAIL random dut%0d ovf/bank got %b/%b want %b/%b", i, err_ovf[i], wr_bank[i], m_err[i], bank_exp(i));
         end
         got_q[i].delete(); exp_q[i].delete();
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] d;
      send_vs(1'b0);
      send_line(0, 8, 1'b0);
      send_line(1, 8, 1'b0);
      for (int h = 0; h < 3; h++) begin
         d = 16'($urandom);
         drive(1'b0, 1'b1, d);
         m_pix(2, h, d, cyc + 1);
      end
      drive(1'b0, 1'b1, 16'($urandom));
      @(negedge clk); #1;
      rst = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         checks++;
         if ({wr_en[i], wr_addr[i], wr_data[i], wr_bank[i], frame_done[i], err_ovf[i]} !== 36'h0) begin
            errors++;
            $display("FAIL reset_mid dut%0d outputs got en=%b addr=%h data=%h bank=%b fd=%b ovf=%b want all 0",
                     i, wr_en[i], wr_addr[i], wr_data[i], wr_bank[i], frame_done[i], err_ovf[i]);
         end
      end
      m_reset();
      drive(1'b0, 1'b1, 16'($urandom));
      drive(1'b0, 1'b1, 16'($urandom));
      rst = 1'b1;
      // Rest of the aborted frame, with no sync: nothing may be written.
      for (int h = 5; h < 8; h++) begin
         d = 16'($urandom);
         drive(1'b0, 1'b1, d);
         m_pix(2, h, d, cyc + 1);
      end
      drive(1'b0, 1'b0, 16'h0);
      m_line_end(2, cyc + 1);
      send_line(3, 8, 1'b0);
      send_line(4, 8, 1'b0);
      send_frame(4, 8, 10, 1'b0);
      repeat (4) drive(1'b0, 1'b0, 16'h0);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (got_q[i].size() != exp_q[i].size()) begin
            errors++;
            $display("FAIL reset_mid dut%0d events got %0d want %0d", i, got_q[i].size(), exp_q[i].size());
         end
         for (int k = 0; k < got_q[i].size() && k < exp_q[i].size(); k++) begin
            checks++;
            if (got_q[i][k] !== exp_q[i][k]) begin
               errors++;
               $display("FAIL reset_mid dut%0d ev%0d got %h want %h", i, k, got_q[i][k], exp_q[i][k]);
            end
         end
         checks++;
         if (err_ovf[i] !== m_err[i] || wr_bank[i] !== bank_exp(i)) begin
            errors++;
            $display("FAIL reset_mid dut%0d ovf/bank got %b/%b want %b/%b", i, err_ovf[i], wr_bank[i], m_err[i], bank_exp(i));
         end
         got_q[i].delete(); exp_q[i].delete();
      end
   endtask

   initial begin
      test_reset();
      test_ref_frame();
      test_long_lines();
      test_vs_mid_frame();
      test_random_frames();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
